// File: rtl/router_sync_pkg.sv
// Shared types and constants for the router synchroniser: address type,
// invalid-address marker, default timeout and the FIFO channel count.
package router_pkg;

  typedef logic [1:0] addr_t;

  localparam addr_t ADDR_INVALID    = 2'b11;
  localparam int    TIMEOUT_DEFAULT = 30;
  localparam int    NUM_CH          = 3;

  // One-hot FIFO write enable for a destination address; an invalid address
  // or an idle request never selects a FIFO.
  function automatic logic [NUM_CH-1:0] addr_to_wen(input addr_t addr, input logic en);
    logic [NUM_CH-1:0] wen;
    wen = 3'b000;
    if (en) begin
      case (addr)
        2'b00:   wen = 3'b001;
        2'b01:   wen = 3'b010;
        2'b10:   wen = 3'b100;
        default: wen = 3'b000;
      endcase
    end else begin
      wen = 3'b000;
    end
    return wen;
  endfunction

endpackage

// File: rtl/router_sync_if.sv
// Bundle of the router-FSM, FIFO-status and downstream-read signals seen by
// router_sync. The slave side is the synchroniser, the master side drives it.
interface router_sync_if;
  import router_pkg::*;

  logic              detect_add;
  addr_t             data_in;
  logic              write_enb_reg;
  logic              read_enb_0, read_enb_1, read_enb_2;
  logic              empty_0, empty_1, empty_2;
  logic              full_0, full_1, full_2;
  logic [NUM_CH-1:0] write_enb;
  logic              fifo_full;
  logic              vld_out_0, vld_out_1, vld_out_2;
  logic              soft_reset_0, soft_reset_1, soft_reset_2;

  modport slave (
    input  detect_add, data_in, write_enb_reg,
    input  read_enb_0, read_enb_1, read_enb_2,
    input  empty_0, empty_1, empty_2,
    input  full_0, full_1, full_2,
    output write_enb, fifo_full,
    output vld_out_0, vld_out_1, vld_out_2,
    output soft_reset_0, soft_reset_1, soft_reset_2
  );

  modport master (
    output detect_add, data_in, write_enb_reg,
    output read_enb_0, read_enb_1, read_enb_2,
    output empty_0, empty_1, empty_2,
    output full_0, full_1, full_2,
    input  write_enb, fifo_full,
    input  vld_out_0, vld_out_1, vld_out_2,
    input  soft_reset_0, soft_reset_1, soft_reset_2
  );

endinterface

// File: rtl/router_sync_timer.sv
// Per-channel unread-data watchdog: counts consecutive cycles where the FIFO
// holds data that nobody reads and emits a one-cycle registered flush pulse
// once TIMEOUT such cycles have elapsed.
module router_sync_timer #(
  parameter int TIMEOUT = 30,
  parameter int CNT_W   = 5
) (
  input  logic clock,
  input  logic resetn,
  input  logic vld,
  input  logic rd,
  output logic soft_reset
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  logic [CNT_W-1:0] r_cnt;
  logic             r_soft_reset;
  logic             w_count_en;

  // The pulse cycle itself does not count, so repeated flushes of a stuck
  // channel are TIMEOUT+1 cycles apart.
  assign w_count_en = vld & ~rd & ~r_soft_reset;

  // Counter and flush pulse; clearing at TIMEOUT-1 keeps the counter from wrapping.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_cnt        <= CNT_ZERO;
      r_soft_reset <= 1'b0;
    end else if (!w_count_en) begin
      r_cnt        <= CNT_ZERO;
      r_soft_reset <= 1'b0;
    end else if (r_cnt == CNT_LAST) begin
      r_cnt        <= CNT_ZERO;
      r_soft_reset <= 1'b1;
    end else begin
      r_cnt        <= r_cnt + CNT_ONE;
      r_soft_reset <= 1'b0;
    end
  end

  assign soft_reset = r_soft_reset;

endmodule

// File: rtl/router_sync.sv
// Router synchroniser: latches the destination address from the header byte,
// steers FIFO write enables and the full flag, reports per-channel valid data
// and flushes channels whose data sits unread for too long.
module router_sync
  import router_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int CNT_W   = 5
) (
  input  logic         clock,
  input  logic         resetn,
  router_sync_if.slave bus
);

  addr_t             r_addr;
  logic              w_fifo_full;
  logic [NUM_CH-1:0] w_vld;
  logic [NUM_CH-1:0] w_rd;
  logic [NUM_CH-1:0] w_soft_reset;

  // Destination address register; reset to the invalid address so nothing
  // is written before the first header arrives.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_addr <= ADDR_INVALID;
    end else if (bus.detect_add) begin
      r_addr <= bus.data_in;
    end else begin
      r_addr <= r_addr;
    end
  end

  // Full flag of the FIFO selected by the registered address.
  always_comb begin
    w_fifo_full = 1'b0;
    case (r_addr)
      2'b00:   w_fifo_full = bus.full_0;
      2'b01:   w_fifo_full = bus.full_1;
      2'b10:   w_fifo_full = bus.full_2;
      default: w_fifo_full = 1'b0;
    endcase
  end

  assign bus.write_enb = addr_to_wen(r_addr, bus.write_enb_reg);
  assign bus.fifo_full = w_fifo_full;

  assign w_vld = {~bus.empty_2, ~bus.empty_1, ~bus.empty_0};
  assign w_rd  = {bus.read_enb_2, bus.read_enb_1, bus.read_enb_0};

  assign bus.vld_out_0 = w_vld[0];
  assign bus.vld_out_1 = w_vld[1];
  assign bus.vld_out_2 = w_vld[2];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_timer
    router_sync_timer #(
      .TIMEOUT (TIMEOUT),
      .CNT_W   (CNT_W)
    ) u_timer (
      .clock      (clock),
      .resetn     (resetn),
      .vld        (w_vld[g]),
      .rd         (w_rd[g]),
      .soft_reset (w_soft_reset[g])
    );
  end

  assign bus.soft_reset_0 = w_soft_reset[0];
  assign bus.soft_reset_1 = w_soft_reset[1];
  assign bus.soft_reset_2 = w_soft_reset[2];

endmodule

// File: tb/tb_router_sync.sv
// Directed self-checking bench for router_sync. Inputs change on the falling
// edge; outputs are checked on the falling edge (registered) or 1 ns after an
// input change (combinational).
module tb_router_sync;
  import router_pkg::*;

  logic clock;
  logic resetn;
  int   n_checks;
  int   n_errors;

  router_sync_if u_if();

  router_sync #(.TIMEOUT(30), .CNT_W(5)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (u_if.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    u_if.detect_add = 1'b0;      u_if.data_in = 2'b00;
    u_if.write_enb_reg = 1'b1;
    u_if.read_enb_0 = 1'b0; u_if.read_enb_1 = 1'b0; u_if.read_enb_2 = 1'b0;
    u_if.empty_0 = 1'b1; u_if.empty_1 = 1'b0; u_if.empty_2 = 1'b1;
    u_if.full_0 = 1'b1; u_if.full_1 = 1'b1; u_if.full_2 = 1'b1;
    tick(); tick();
    n_checks++;
    if (u_if.write_enb !== 3'b000) begin
      n_errors++; $display("FAIL reset_write_enb: got %b expected 000", u_if.write_enb);
    end
    n_checks++;
    if (u_if.fifo_full !== 1'b0) begin
      n_errors++; $display("FAIL reset_fifo_full: got %b expected 0", u_if.fifo_full);
    end
    n_checks++;
    if ({u_if.soft_reset_2, u_if.soft_reset_1, u_if.soft_reset_0} !== 3'b000) begin
      n_errors++; $display("FAIL reset_soft_reset: got %b expected 000",
                           {u_if.soft_reset_2, u_if.soft_reset_1, u_if.soft_reset_0});
    end
    n_checks++;
    if ({u_if.vld_out_2, u_if.vld_out_1, u_if.vld_out_0} !== 3'b010) begin
      n_errors++; $display("FAIL reset_vld_out: got %b expected 010",
                           {u_if.vld_out_2, u_if.vld_out_1, u_if.vld_out_0});
    end
    u_if.empty_1 = 1'b1;
    #1;
    n_checks++;
    if (u_if.vld_out_1 !== 1'b0) begin
      n_errors++; $display("FAIL reset_vld_follow: got %b expected 0", u_if.vld_out_1);
    end
    u_if.write_enb_reg = 1'b0;
    u_if.full_0 = 1'b0; u_if.full_1 = 1'b0; u_if.full_2 = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
  endtask

  task automatic test_no_header();
    u_if.write_enb_reg = 1'b1;
    u_if.full_0 = 1'b1; u_if.full_1 = 1'b1; u_if.full_2 = 1'b1;
    #1;
    n_checks++;
    if (u_if.write_enb !== 3'b000) begin
      n_errors++; $display("FAIL nohdr_write_enb: got %b expected 000", u_if.write_enb);
    end
    n_checks++;
    if (u_if.fifo_full !== 1'b0) begin
      n_errors++; $display("FAIL nohdr_fifo_full: got %b expected 0", u_if.fifo_full);
    end
    tick();
    n_checks++;
    if ({u_if.soft_reset_2, u_if.soft_reset_1, u_if.soft_reset_0} !== 3'b000) begin
      n_errors++; $display("FAIL nohdr_soft_reset: got %b expected 000",
                           {u_if.soft_reset_2, u_if.soft_reset_1, u_if.soft_reset_0});
    end
    u_if.write_enb_reg = 1'b0;
    u_if.full_0 = 1'b0; u_if.full_1 = 1'b0; u_if.full_2 = 1'b0;
  endtask

  task automatic test_addr_write();
    logic [2:0] exp_wen [4];
    logic [1:0] addrs [4];
    u_if.detect_add = 1'b1; u_if.data_in = 2'b01;
    tick();
    u_if.detect_add = 1'b0; u_if.data_in = 2'b11;
    u_if.write_enb_reg = 1'b1;
    for (int i = 0; i < 4; i++) begin
      u_if.full_0 = i[0]; u_if.full_1 = ~i[0]; u_if.full_2 = i[0];
      #1;
      n_checks++;
      if (u_if.write_enb !== 3'b010) begin
        n_errors++; $display("FAIL addr1_write_enb[%0d]: got %b expected 010", i, u_if.write_enb);
      end
      n_checks++;
      if (u_if.fifo_full !== ~i[0]) begin
        n_errors++; $display("FAIL addr1_fifo_full[%0d]: got %b expected %b", i, u_if.fifo_full, ~i[0]);
      end
      tick();
    end
    u_if.write_enb_reg = 1'b0;
    #1;
    n_checks++;
    if (u_if.write_enb !== 3'b000) begin
      n_errors++; $display("FAIL addr1_idle_write_enb: got %b expected 000", u_if.write_enb);
    end
    // Walk the other addresses, each with only its own FIFO full.
    addrs[0] = 2'b00; exp_wen[0] = 3'b001;
    addrs[1] = 2'b10; exp_wen[1] = 3'b100;
    addrs[2] = 2'b11; exp_wen[2] = 3'b000;
    addrs[3] = 2'b01; exp_wen[3] = 3'b010;
    for (int i = 0; i < 4; i++) begin
      u_if.detect_add = 1'b1; u_if.data_in = addrs[i];
      tick();
      u_if.detect_add = 1'b0; u_if.data_in = 2'b00;
      u_if.write_enb_reg = 1'b1;
      {u_if.full_2, u_if.full_1, u_if.full_0} = (addrs[i] == 2'b11) ? 3'b111 : exp_wen[i];
      #1;
      n_checks++;
      if (u_if.write_enb !== exp_wen[i]) begin
        n_errors++; $display("FAIL addr_walk_write_enb[%0d]: got %b expected %b", i, u_if.write_enb, exp_wen[i]);
      end
      n_checks++;
      if (u_if.fifo_full !== (addrs[i] != 2'b11)) begin
        n_errors++; $display("FAIL addr_walk_fifo_full[%0d]: got %b expected %b", i, u_if.fifo_full, addrs[i] != 2'b11);
      end
      {u_if.full_2, u_if.full_1, u_if.full_0} = 3'b000;
      #1;
      n_checks++;
      if (u_if.fifo_full !== 1'b0) begin
        n_errors++; $display("FAIL addr_walk_not_full[%0d]: got %b expected 0", i, u_if.fifo_full);
      end
      u_if.write_enb_reg = 1'b0;
      @(negedge clock);
    end
  endtask

  task automatic test_same_cycle();
    u_if.detect_add = 1'b1; u_if.data_in = 2'b00;
    tick();
    u_if.data_in = 2'b10; u_if.write_enb_reg = 1'b1;
    #1;
    n_checks++;
    if (u_if.write_enb !== 3'b001) begin
      n_errors++; $display("FAIL same_cycle_old_addr: got %b expected 001", u_if.write_enb);
    end
    tick();
    u_if.detect_add = 1'b0; u_if.data_in = 2'b00;
    #1;
    n_checks++;
    if (u_if.write_enb !== 3'b100) begin
      n_errors++; $display("FAIL same_cycle_new_addr: got %b expected 100", u_if.write_enb);
    end
    u_if.write_enb_reg = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_timeout_ch2();
    logic exp;
    u_if.empty_2 = 1'b0; u_if.read_enb_2 = 1'b0;
    for (int i = 1; i <= 62; i++) begin
      tick();
      exp = (i == 30) || (i == 61);
      n_checks++;
      if (u_if.soft_reset_2 !== exp) begin
        n_errors++; $display("FAIL timeout_ch2 cycle %0d: got %b expected %b", i, u_if.soft_reset_2, exp);
      end
    end
    u_if.empty_2 = 1'b1;
    tick();
  endtask

  task automatic test_read_suppress();
    logic exp;
    u_if.empty_0 = 1'b0;
    for (int i = 1; i <= 61; i++) begin
      u_if.read_enb_0 = (i == 30);
      tick();
      exp = (i == 60);
      n_checks++;
      if (u_if.soft_reset_0 !== exp) begin
        n_errors++; $display("FAIL read_suppress_ch0 cycle %0d: got %b expected %b", i, u_if.soft_reset_0, exp);
      end
    end
    u_if.read_enb_0 = 1'b0;
    u_if.empty_0 = 1'b1;
    tick();
  endtask

  task automatic test_reset_during_count();
    logic exp;
    u_if.empty_1 = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    resetn = 1'b0;
    #1;
    n_checks++;
    if (u_if.soft_reset_1 !== 1'b0) begin
      n_errors++; $display("FAIL rst_mid_count_pulse: got %b expected 0", u_if.soft_reset_1);
    end
    tick();
    resetn = 1'b1;
    for (int i = 1; i <= 31; i++) begin
      tick();
      exp = (i == 30);
      n_checks++;
      if (u_if.soft_reset_1 !== exp) begin
        n_errors++; $display("FAIL rst_mid_count ch1 cycle %0d: got %b expected %b", i, u_if.soft_reset_1, exp);
      end
    end
    u_if.empty_1 = 1'b1;
    tick();
  endtask

  task automatic test_simultaneous();
    logic [2:0] exp;
    logic [2:0] got;
    u_if.empty_0 = 1'b0; u_if.empty_1 = 1'b0; u_if.empty_2 = 1'b0;
    for (int i = 1; i <= 31; i++) begin
      // Channel 1 is read once early, so it lags the others by 10 cycles.
      u_if.read_enb_1 = (i == 10);
      tick();
      exp = {(i == 30), (i == 30) ? 1'b0 : 1'b0, (i == 30)};
      got = {u_if.soft_reset_2, u_if.soft_reset_1, u_if.soft_reset_0};
      n_checks++;
      if (got !== exp) begin
        n_errors++; $display("FAIL simultaneous cycle %0d: got %b expected %b", i, got, exp);
      end
    end
    u_if.read_enb_1 = 1'b0;
    u_if.empty_0 = 1'b1; u_if.empty_1 = 1'b1; u_if.empty_2 = 1'b1;
    tick();
    u_if.empty_0 = 1'b0; u_if.empty_1 = 1'b0; u_if.empty_2 = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      exp = (i == 30) ? 3'b111 : 3'b000;
      got = {u_if.soft_reset_2, u_if.soft_reset_1, u_if.soft_reset_0};
      n_checks++;
      if (got !== exp) begin
        n_errors++; $display("FAIL all_channels cycle %0d: got %b expected %b", i, got, exp);
      end
    end
    u_if.empty_0 = 1'b1; u_if.empty_1 = 1'b1; u_if.empty_2 = 1'b1;
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    @(negedge clock);
    test_reset();
    test_no_header();
    test_addr_write();
    test_same_cycle();
    test_timeout_ch2();
    test_read_suppress();
    test_reset_during_count();
    test_simultaneous();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/router_sync.md
ROUTER_SYNC -- requirements
Module: router_sync

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 30, meaning the number of consecutive unread cycles with valid data before a channel soft reset.
REQ-002 The block SHALL have parameter CNT_W, default 5, meaning the timeout counter width, with 2**CNT_W >= TIMEOUT.
REQ-003 The block SHALL have port clock  input  1  the single rising-edge clock for all state.
REQ-004 The block SHALL have port resetn  input  1  the asynchronous active-low reset.
REQ-005 The block SHALL have port detect_add  input  1  the header-byte strobe from the router FSM that latches the destination address.
REQ-006 The block SHALL have port data_in  input  2  the destination address (bits [1:0] of the header byte).
REQ-007 The block SHALL have port write_enb_reg  input  1  the FSM request to write the current byte into the addressed FIFO.
REQ-008 The block SHALL have ports read_enb_0/1/2  input  1 each  the downstream read strobes per channel.
REQ-009 The block SHALL have ports empty_0/1/2 and full_0/1/2  input  1 each  the FIFO status flags per channel.
REQ-010 The block SHALL have port write_enb  output  3  the one-hot FIFO write enables, with bit n driving FIFO n.
REQ-011 The block SHALL have port fifo_full  output  1  the full flag of the addressed FIFO.
REQ-012 The block SHALL have ports vld_out_0/1/2  output  1 each  the data-available indication per channel.
REQ-013 The block SHALL have ports soft_reset_0/1/2  output  1 each  the per-FIFO timeout flush pulse.

Function
REQ-014 The address register SHALL load data_in on a rising clock edge when detect_add=1, and SHALL hold its value otherwise.
REQ-015 write_enb SHALL be combinational from the registered address and write_enb_reg: 001, 010 or 100 for address 0, 1 or 2 when write_enb_reg=1, and 000 otherwise.
REQ-016 For address 2'b11 (invalid), write_enb SHALL be 000 and fifo_full SHALL be 0.
REQ-017 When detect_add and write_enb_reg are high in the same cycle, the write SHALL use the previously registered address; the new address SHALL take effect from the next cycle.
REQ-018 fifo_full SHALL be a combinational mux of full_0/1/2 selected by the registered address.
REQ-019 vld_out_n SHALL equal ~empty_n combinationally, with zero latency.
REQ-020 Each channel n SHALL have a counter that increments on each cycle where vld_out_n=1 and read_enb_n=0.
REQ-021 Each channel counter SHALL clear to 0 in any cycle where read_enb_n=1 or vld_out_n=0.
REQ-022 When a counter equals TIMEOUT-1 and the increment condition holds, soft_reset_n SHALL be high for exactly one cycle on the next edge, and the counter SHALL clear to 0.
REQ-023 soft_reset_n SHALL therefore assert after TIMEOUT consecutive unread valid cycles, and SHALL be registered (glitch-free).
REQ-024 In the cycle where soft_reset_n=1, the counter SHALL hold 0; if the FIFO is still non-empty and unread afterwards, counting SHALL restart from 0.
REQ-025 A read_enb_n pulse in the cycle where the counter equals TIMEOUT-1 SHALL suppress the soft_reset_n pulse.
REQ-026 The three channels SHALL operate independently; simultaneous timeouts SHALL pulse all affected soft_reset outputs in the same cycle.
REQ-027 Counters SHALL never wrap, because they saturate by clearing at TIMEOUT-1.

Reset
REQ-028 When resetn=0, asynchronously: address register SHALL be 2'b11, all counters SHALL be 0, soft_reset_0/1/2 SHALL be 0, and write_enb SHALL be 000.
REQ-029 While resetn=0, fifo_full SHALL be 0 and vld_out_n SHALL follow ~empty_n.
REQ-030 A reset during counting SHALL discard the count, so no soft_reset pulse follows the release of reset.

Structure
REQ-031 Package router_pkg SHALL hold typedef addr_t (2-bit), constants ADDR_INVALID=2'b11 and TIMEOUT_DEFAULT=30, and the channel count NUM_CH=3.
REQ-032 The per-channel counter and pulse logic SHALL be the sub-module router_sync_timer (ports: clock, resetn, vld, rd, soft_reset; parameters TIMEOUT, CNT_W), instantiated three times.

Verification
REQ-033 Release reset with no header, then pulse write_enb_reg -> write_enb=000, fifo_full=0, soft_reset_0/1/2 all 0.
REQ-034 Pulse detect_add with data_in=2'b01, then write_enb_reg=1 for 4 cycles -> write_enb=010 in those cycles; with full_1=1, fifo_full=1 and full_0 is ignored.
REQ-035 Hold empty_2=0 and read_enb_2=0 -> soft_reset_2 is high for exactly one cycle after 30 cycles, then pulses again 31 cycles later if still unread.
REQ-036 Hold empty_0=0, pulse read_enb_0 at cycle 29 -> no soft_reset_0; the pulse then occurs 30 cycles after the read.
REQ-037 Pulse detect_add with data_in=2'b10 in the same cycle as write_enb_reg=1 while the registered address is 00 -> write_enb=001 that cycle and 100 the next cycle.
REQ-038 Drive resetn low at count 20 on channel 1, then release -> counter is 0 and soft_reset_1 is first seen 30 cycles after release.
